// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame_tx_101 serial framer.
//   state_t  : FSM state encoding (IDLE, PRE, DATA, PAR, GAP)
//   PREAMBLE : preamble pattern, sent MSB-first (1,0,1)
//   PRE_LEN  : number of preamble bits
//   CNT_W    : width of the shared bit/gap counter (covers DATA_W<=32, GAP_LEN<=15)
package frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  localparam logic [2:0] PREAMBLE = 3'b101;
  localparam int         PRE_LEN  = 3;
  localparam int         CNT_W    = 6;

endpackage

// File: rtl/frame_tx_101_piso_shift.sv
// piso_shift: parallel-in / serial-out payload register.
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset, clears the register
//   load  : capture din (has priority over shift)
//   shift : move the register one place toward the MSB
//   din   : parallel payload
//   msb   : current most-significant bit (next bit to transmit)
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    // NOTE: the payload register is cleared on reset so an aborted frame
    // leaves no stale data behind; a data-only RAM would not need this.
    if (!rst)       sr_q <= '0;
    else if (load)  sr_q <= din;
    else if (shift) sr_q <= sr_q << 1;
  end

  assign msb = sr_q[DATA_W-1];

endmodule

// File: rtl/frame_tx_101.sv
// frame_tx_101: serialises one payload per handshake into a framed bit stream
//   preamble 1,0,1 | DATA_W data bits MSB-first | even parity (if PAR_EN)
// followed by GAP_LEN forced idle cycles.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   in_valid : payload offered
//   in_data  : payload
//   in_ready : high only in IDLE
//   tx       : serial output, one bit per clock (registered)
//   tx_valid : tx carries a frame bit (registered)
//   busy     : frame or gap in progress (registered)
//   done     : one-cycle pulse with the last frame bit (registered)
// The state register names the state of the bit currently on tx, so every
// output is computed one cycle ahead and registered alongside the state.
module frame_tx_101
  import frame_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAR_EN  = 1,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              tx_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic             HAS_PAR   = (PAR_EN != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q;
  logic             tx_d, tx_valid_d, busy_d, done_d;
  logic             load, shift, sr_msb, handshake;
  logic [1:0]       pre_idx;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .msb   (sr_msb)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign handshake = in_valid && in_ready;
  // Preamble bit to emit after the one at index cnt_q (bit 2 goes out first).
  assign pre_idx   = 2'(PRE_LEN - 2) - cnt_q[1:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = 1'b0;
    tx_valid_d = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (handshake) begin
          state_d    = S_PRE;
          cnt_d      = '0;
          tx_d       = PREAMBLE[PRE_LEN-1];
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          load       = 1'b1;
        end
      end

      S_PRE: begin
        tx_valid_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          // First data bit goes out while the register advances to the next.
          state_d = S_DATA;
          cnt_d   = '0;
          tx_d    = sr_msb;
          shift   = 1'b1;
          done_d  = !HAS_PAR && (DATA_W == 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = PREAMBLE[pre_idx];
        end
      end

      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
          if (HAS_PAR) begin
            state_d    = S_PAR;
            tx_d       = par_q;
            tx_valid_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d      = cnt_q + 1'b1;
          tx_d       = sr_msb;
          tx_valid_d = 1'b1;
          shift      = 1'b1;
          done_d     = !HAS_PAR && (cnt_q == DATA_PEN);
        end
      end

      S_PAR: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx       <= tx_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
      done     <= done_d;
      // Even parity over the payload as captured, independent of later in_data.
      if (load) par_q <= ^in_data;
    end
  end

endmodule

// File: tb/tb_frame_tx_101.sv
// Directed bench for frame_tx_101: default instance (DATA_W=8, PAR_EN=1,
// GAP_LEN=2) plus a DATA_W=4, PAR_EN=0 instance sharing clock and reset.
module tb_frame_tx_101;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, tx, tx_valid, busy, done;

  logic       in_valid4;
  logic [3:0] in_data4;
  logic       in_ready4, tx4, tx_valid4, busy4, done4;

  int n_total = 0;
  int n_bad   = 0;

  int cyc     = 0;
  int hs_n    = 0;
  int last_hs = 0;
  int hs_gap  = 0;
  int done_n  = 0;

  always #5 clk = ~clk;

  frame_tx_101 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  frame_tx_101 #(.DATA_W(4), .PAR_EN(0), .GAP_LEN(2)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid4),
    .in_data  (in_data4),
    .in_ready (in_ready4),
    .tx       (tx4),
    .tx_valid (tx_valid4),
    .busy     (busy4),
    .done     (done4)
  );

  // Handshake spacing and done-pulse bookkeeping for the default instance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && in_valid && in_ready) begin
      if (hs_n > 0) hs_gap = cyc - last_hs;
      last_hs = cyc;
      hs_n = hs_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first frame cycle; checks 12 frame bits, the gap and the
  // return to IDLE. With toggle set, in_data flips every cycle and in_valid
  // is raised during the gap.
  task automatic frame_check(input string tag, input logic [11:0] exp_bits, input bit toggle);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s tx[%0d]", tag, i), 32'(tx), 32'(exp_bits[11-i]));
      check($sformatf("%s tx_valid[%0d]", tag, i), 32'(tx_valid), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(done), 32'(i == 11));
      check($sformatf("%s in_ready[%0d]", tag, i), 32'(in_ready), 32'd0);
      if (toggle) in_data = ~in_data;
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s gap tx[%0d]", tag, g), 32'(tx), 32'd0);
      check($sformatf("%s gap tx_valid[%0d]", tag, g), 32'(tx_valid), 32'd0);
      check($sformatf("%s gap busy[%0d]", tag, g), 32'(busy), 32'd1);
      check($sformatf("%s gap in_ready[%0d]", tag, g), 32'(in_ready), 32'd0);
      check($sformatf("%s gap done[%0d]", tag, g), 32'(done), 32'd0);
      if (toggle) in_valid = 1'b1;
      tick();
    end
    if (toggle) in_valid = 1'b0;
    check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [6:0] exp4;
    int d0;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_valid4 = 1'b0;
    in_data4  = 4'h0;
    tick();
    tick();

    // Reset state.
    check("rst tx", 32'(tx), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // First edge after release with in_valid high accepts 8'hA5.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    frame_check("a5", 12'hB4A, 1'b0);

    // Parity bit 1 for 8'h01.
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    in_valid = 1'b0;
    frame_check("01", 12'hA03, 1'b0);

    // Back-to-back with in_valid held: 8'h3C then 8'hC3.
    d0       = done_n;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_data  = 8'hC3;
    frame_check("3c", 12'hA78, 1'b0);
    tick();
    frame_check("c3", 12'hB86, 1'b0);
    in_valid = 1'b0;
    check("b2b hs interval", 32'(hs_gap), 32'd15);
    tick();
    check("b2b done pulses", 32'(done_n - d0), 32'd2);

    // Reset in cycle 6 of a frame.
    d0       = done_n;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    check("abort tx", 32'(tx), 32'd0);
    check("abort tx_valid", 32'(tx_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    // Reset still low with in_valid high: reset wins over the handshake.
    tick();
    check("rst prio busy", 32'(busy), 32'd0);
    check("abort no done", 32'(done_n - d0), 32'd0);
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    frame_check("post-abort", 12'hA03, 1'b0);

    // in_data churn during the frame and in_valid during the gap.
    d0       = done_n;
    in_valid = 1'b1;
    in_data  = 8'h96;
    tick();
    in_valid = 1'b0;
    frame_check("96", 12'hB2C, 1'b1);
    tick();
    check("no extra frame busy", 32'(busy), 32'd0);
    check("no extra frame tx_valid", 32'(tx_valid), 32'd0);
    check("96 done pulses", 32'(done_n - d0), 32'd1);

    // DATA_W=4, PAR_EN=0, 4'b1001.
    exp4      = 7'b1011001;
    in_valid4 = 1'b1;
    in_data4  = 4'b1001;
    tick();
    in_valid4 = 1'b0;
    in_data4  = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("w4 tx[%0d]", i), 32'(tx4), 32'(exp4[6-i]));
      check($sformatf("w4 tx_valid[%0d]", i), 32'(tx_valid4), 32'd1);
      check($sformatf("w4 done[%0d]", i), 32'(done4), 32'(i == 6));
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("w4 gap tx_valid[%0d]", g), 32'(tx_valid4), 32'd0);
      check($sformatf("w4 gap busy[%0d]", g), 32'(busy4), 32'd1);
      tick();
    end
    check("w4 idle in_ready", 32'(in_ready4), 32'd1);
    check("w4 idle busy", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_101.md
FRAME_TX_101 -- requirements
Module: frame_tx_101

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (range 1..32).
REQ-002 Parameter PAR_EN, default 1, 1 appends an even-parity bit after the payload.
REQ-003 Parameter GAP_LEN, default 2, forced idle (tx=0) cycles after each frame (range 1..15).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  payload offered.
REQ-007 in_data  input  DATA_W  payload, transmitted MSB-first.
REQ-008 in_ready  output  1  block can accept a payload this cycle.
REQ-009 tx  output  1  serial bit stream, one bit per clk.
REQ-010 tx_valid  output  1  tx carries a frame bit (preamble, data or parity).
REQ-011 busy  output  1  frame or gap in progress.
REQ-012 done  output  1  one-cycle pulse coincident with the last frame bit on tx.

Function
REQ-013 Frame format SHALL be preamble 1,0,1, then DATA_W data bits MSB-first, then the parity bit if PAR_EN=1; frame length F = 3 + DATA_W + PAR_EN cycles.
REQ-014 States SHALL be IDLE, PRE, DATA, PAR, GAP; PAR is skipped when PAR_EN=0.
REQ-015 in_ready SHALL be 1 only in IDLE; a handshake is in_valid && in_ready at a rising edge.
REQ-016 On handshake, in_data SHALL be captured; changes to in_data after capture SHALL have no effect on the frame.
REQ-017 tx, tx_valid, busy and done SHALL be registered: the first preamble bit appears on tx in the cycle after the handshake edge.
REQ-018 Transitions: IDLE->PRE on handshake; PRE->DATA after 3 bits; DATA->PAR (or GAP) after DATA_W bits; PAR->GAP after 1 bit; GAP->IDLE after GAP_LEN cycles.
REQ-019 Parity bit SHALL be the XOR of all captured data bits, giving even parity over the data.
REQ-020 In IDLE and GAP, tx=0 and tx_valid=0; in PRE, DATA and PAR, tx_valid=1.
REQ-021 busy SHALL be 1 in PRE, DATA, PAR and GAP, and 0 in IDLE.
REQ-022 done SHALL be 1 for exactly one cycle per frame, on the last frame bit, and 0 otherwise.
REQ-023 With in_valid held high, consecutive frames SHALL be separated by exactly GAP_LEN idle cycles plus 1 IDLE handshake cycle, so the handshake interval is F+GAP_LEN+1 cycles.
REQ-024 in_valid while not in IDLE SHALL be ignored and SHALL not be queued.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, tx=0, tx_valid=0, busy=0, done=0, in_ready=1 on the following cycle, clear the shift register and counters, and take priority over a simultaneous handshake.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse; the next frame SHALL start with a full preamble.
REQ-027 On the first edge with rst=1 and in_valid=1, the block SHALL accept the payload.

Structure
REQ-028 Package frame_tx_pkg SHALL hold the state enum typedef and constants PREAMBLE=3'b101 and PRE_LEN=3.
REQ-029 One sub-module piso_shift (DATA_W-bit parallel-load, MSB-first serial shift, load and shift enables) SHALL hold the payload; the FSM, bit counter and parity SHALL live in frame_tx_101.

Verification
REQ-030 Defaults, in_data=8'hA5 single pulse -> tx = 1,0,1,1,0,1,0,0,1,0,1,0 over 12 cycles, done on the 12th, then 2 cycles tx=0 with in_ready=0.
REQ-031 in_data=8'h01 -> parity bit 1, tx ends ...,0,0,0,0,0,0,0,1,1.
REQ-032 in_valid held high with 8'h3C then 8'hC3 -> handshakes exactly 15 cycles apart, both frames correct, exactly two done pulses.
REQ-033 rst=0 at cycle 6 of a frame -> next cycle tx=0, busy=0, in_ready=1, no done; a new frame after release starts with 1,0,1.
REQ-034 PAR_EN=0, DATA_W=4, in_data=4'b1001 -> tx = 1,0,1,1,0,0,1 over 7 cycles, done on the 7th.
REQ-035 in_data toggled every cycle during a frame, and in_valid pulsed during GAP -> transmitted bits match the captured value, and no extra frame is started.
